// File: rtl/tempo_pkg.sv
// tempo_pkg: shared types and constant helpers for tempo_controller.
// Tracker state enum, cycle-count constants and the BPM clamp.
package tempo_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      DIVIDE,
      UPDATE
   } trk_state_t;

   // Cycles per minute.
   function automatic longint full_cycles(input longint clk_hz);
      return 60 * clk_hz;
   endfunction

   // Longest legal beat interval, in cycles.
   function automatic longint timeout_cycles(input longint clk_hz,
                                             input longint bpm_min);
      return full_cycles(clk_hz) / bpm_min;
   endfunction

   // Shortest legal beat interval, in cycles.
   function automatic longint min_int_cycles(input longint clk_hz,
                                             input longint bpm_max);
      return full_cycles(clk_hz) / bpm_max;
   endfunction

   // Bits needed to hold FULL; also the divider step count.
   function automatic int div_width(input longint clk_hz);
      longint full;
      int     w;
      full = full_cycles(clk_hz);
      w    = 0;
      while ((longint'(1) << w) < full + 1) w = w + 1;
      return w;
   endfunction

   function automatic logic [7:0] clamp_bpm(input logic [63:0] v,
                                            input int          lo,
                                            input int          hi);
      if (v < 64'(lo))
         return 8'(lo);
      else if (v > 64'(hi))
         return 8'(hi);
      else
         return v[7:0];
   endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring divider, one quotient bit per cycle.
// Ports: start/dividend/divisor in; busy, done (1-cycle), quotient out.
module seq_divider #(
   parameter int W = 16
) (
   input  logic         clk_camera_in,
   input  logic         rst_in,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]  rem;
   logic [W:0]    shifted;
   logic [W-1:0]  dsr;
   logic [W-1:0]  q;
   logic [CW-1:0] cnt;
   logic          fits;

   // q starts as the dividend and fills with quotient bits as it shifts.
   assign shifted  = {rem, q[W-1]};
   assign fits     = shifted >= {1'b0, dsr};
   assign quotient = q;

   always_ff @(posedge clk_camera_in or posedge rst_in) begin
      if (rst_in) begin
         rem  <= '0;
         dsr  <= '0;
         q    <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem  <= '0;
            q    <= dividend;
            dsr  <= divisor;
            cnt  <= CW'(W);
            busy <= 1'b1;
         end else if (busy) begin
            rem <= fits ? W'(shifted - {1'b0, dsr})
                        : shifted[W-1:0];
            q   <= {q[W-2:0], fits};
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tempo_controller.sv
// tempo_controller: beat-interval tracker, manual/tracked arbitration
// and phase-accumulator beat tick. Ports: beat/auto/manual in;
// bpm_out, bpm_valid_out, source_out, beat_tick_out registered out.
module tempo_controller #(
   parameter int CLK_HZ      = 25_000_000,
   parameter int DEFAULT_BPM = 60,
   parameter int BPM_MIN     = 30,
   parameter int BPM_MAX     = 240
) (
   input  logic       clk_camera_in,
   input  logic       rst_in,
   input  logic       beat_in,
   input  logic       auto_en_in,
   input  logic       manual_load_in,
   input  logic [7:0] bpm_manual_in,
   output logic [7:0] bpm_out,
   output logic       bpm_valid_out,
   output logic       source_out,
   output logic       beat_tick_out
);

   import tempo_pkg::*;

   localparam longint HZ   = longint'(CLK_HZ);
   localparam int     DIVW = div_width(HZ);

   localparam logic [DIVW-1:0] FULL_V =
      DIVW'(full_cycles(HZ));
   localparam logic [DIVW-1:0] TO_V =
      DIVW'(timeout_cycles(HZ, longint'(BPM_MIN)));
   localparam logic [DIVW-1:0] MIN_V =
      DIVW'(min_int_cycles(HZ, longint'(BPM_MAX)));
   localparam logic [DIVW-1:0] ONE = DIVW'(1);
   localparam logic [35:0] FULL_A =
      36'(full_cycles(HZ));

   trk_state_t      state;
   logic [DIVW-1:0] ic;
   logic [DIVW-1:0] ic_inc;
   logic [DIVW-1:0] div_q;
   logic            div_start;
   logic            div_busy;
   logic            div_done;

   logic [7:0] hist [4];
   logic       hist_full;
   logic [7:0] h_new [4];
   logic [7:0] q_bpm;
   logic [7:0] avg;
   logic [7:0] man_bpm;
   logic [9:0] sum;

   logic [35:0] acc;
   logic [35:0] acc_sum;

   assign ic_inc = (ic == TO_V) ? ic : ic + ONE;

   // A beat inside the legal window ends the interval; shorter is bounce.
   assign div_start = (state == ARMED) && beat_in && !div_busy
                    && (ic >= MIN_V) && (ic < TO_V);

   assign man_bpm = clamp_bpm(64'(bpm_manual_in), BPM_MIN, BPM_MAX);

   seq_divider #(
      .W (DIVW)
   ) u_div (
      .clk_camera_in (clk_camera_in),
      .rst_in        (rst_in),
      .start         (div_start),
      .dividend      (FULL_V),
      .divisor       (ic + ONE),
      .busy          (div_busy),
      .done          (div_done),
      .quotient      (div_q)
   );

   // Empty history is seeded with the first result in every slot.
   always_comb begin
      q_bpm    = clamp_bpm(64'(div_q), BPM_MIN, BPM_MAX);
      h_new[0] = q_bpm;
      for (int i = 1; i < 4; i++)
         h_new[i] = hist_full ? hist[i-1] : q_bpm;
      sum = 10'(h_new[0]) + 10'(h_new[1])
          + 10'(h_new[2]) + 10'(h_new[3]);
      avg = 8'(sum >> 2);
   end

   always_ff @(posedge clk_camera_in or posedge rst_in) begin
      if (rst_in) begin
         state         <= IDLE;
         ic            <= '0;
         hist_full     <= 1'b0;
         bpm_out       <= 8'(DEFAULT_BPM);
         bpm_valid_out <= 1'b0;
         source_out    <= 1'b0;
         for (int i = 0; i < 4; i++)
            hist[i] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (beat_in) begin
                  ic    <= '0;
                  state <= ARMED;
               end
            end
            ARMED: begin
               if (ic == TO_V) begin
                  state     <= IDLE;
                  hist_full <= 1'b0;
               end else if (div_start) begin
                  ic    <= '0;
                  state <= DIVIDE;
               end else begin
                  ic <= ic_inc;
               end
            end
            DIVIDE: begin
               ic <= beat_in ? '0 : ic_inc;
               if (div_done)
                  state <= UPDATE;
            end
            UPDATE: begin
               ic    <= beat_in ? '0 : ic_inc;
               state <= ARMED;
               if (!manual_load_in) begin
                  hist      <= h_new;
                  hist_full <= 1'b1;
                  if (auto_en_in) begin
                     bpm_out       <= avg;
                     source_out    <= 1'b1;
                     bpm_valid_out <= 1'b1;
                  end
               end
            end
         endcase

         // Manual load overrides any tracked result in this cycle.
         if (manual_load_in) begin
            bpm_out       <= man_bpm;
            source_out    <= 1'b0;
            bpm_valid_out <= 1'b1;
            hist_full     <= 1'b0;
         end
      end
   end

   // Phase accumulator: one tick each time the phase wraps FULL.
   assign acc_sum = acc + {28'd0, bpm_out};

   always_ff @(posedge clk_camera_in or posedge rst_in) begin
      if (rst_in) begin
         acc           <= '0;
         beat_tick_out <= 1'b0;
      end else if (acc_sum >= FULL_A) begin
         acc           <= acc_sum - FULL_A;
         beat_tick_out <= 1'b1;
      end else begin
         acc           <= acc_sum;
         beat_tick_out <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tempo_controller.sv
// tb_tempo_controller: scoreboard bench for tempo_controller.
// Time-based reference model predicts tempo changes and tick edges.
module tb_tempo_controller;

   localparam int CLK_HZ  = 600;
   localparam int FULL    = 60 * CLK_HZ;
   localparam int BMIN    = 30;
   localparam int BMAX    = 240;
   localparam int DEF     = 60;
   localparam int TIMEOUT = FULL / BMIN;
   localparam int MIN_INT = FULL / BMAX;
   localparam int DIVW    = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       beat = 1'b0;
   logic       auto_en = 1'b0;
   logic       mload = 1'b0;
   logic [7:0] mval = 8'd0;
   logic [7:0] bpm;
   logic       valid;
   logic       src;
   logic       tick;

   tempo_controller #(
      .CLK_HZ      (CLK_HZ),
      .DEFAULT_BPM (DEF),
      .BPM_MIN     (BMIN),
      .BPM_MAX     (BMAX)
   ) dut (
      .clk_camera_in  (clk),
      .rst_in         (rst),
      .beat_in        (beat),
      .auto_en_in     (auto_en),
      .manual_load_in (mload),
      .bpm_manual_in  (mval),
      .bpm_out        (bpm),
      .bpm_valid_out  (valid),
      .source_out     (src),
      .beat_tick_out  (tick)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int cyc;
      int bpm;
      bit src;
      bit valid;
   } ev_t;

   ev_t chg_q [$];
   int  tick_q [$];
   int  edge_n = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic flag(string nm, int cyc);
      n_checks++;
      n_fail++;
      $display("FAIL %s: at edge %0d (expected edge %0d)", nm, edge_n, cyc);
   endtask

   // ---------------- reference model ----------------
   bit     m_armed;
   bit     m_busy;
   int     m_anchor;
   int     m_upd_edge;
   int     m_interval;
   int     m_hist [$];
   int     m_bpm;
   bit     m_src;
   bit     m_valid;
   longint m_phase;

   function automatic int clampi(int v);
      if (v < BMIN) return BMIN;
      if (v > BMAX) return BMAX;
      return v;
   endfunction

   task automatic m_reset();
      m_armed = 0;
      m_busy  = 0;
      m_hist.delete();
      m_bpm   = DEF;
      m_src   = 0;
      m_valid = 0;
      m_phase = 0;
   endtask

   task automatic m_step();
      int  nb;
      bit  ns;
      bit  nv;
      int  gap;
      int  q;
      int  s;
      ev_t ev;
      nb = m_bpm;
      ns = m_src;
      nv = m_valid;
      if ((m_phase + m_bpm) / FULL > m_phase / FULL)
         tick_q.push_back(edge_n);
      m_phase += m_bpm;
      if (m_busy) begin
         if (beat) m_anchor = edge_n;
         if (edge_n == m_upd_edge) begin
            m_busy = 0;
            if (!mload) begin
               q = clampi(FULL / m_interval);
               if (m_hist.size() == 0)
                  repeat (4) m_hist.push_back(q);
               else begin
                  m_hist.push_front(q);
                  void'(m_hist.pop_back());
               end
               s = 0;
               foreach (m_hist[i]) s += m_hist[i];
               if (auto_en) begin
                  nb = s / 4;
                  ns = 1;
                  nv = 1;
               end
            end
         end
      end else if (m_armed) begin
         gap = edge_n - 1 - m_anchor;
         if (gap >= TIMEOUT) begin
            m_armed = 0;
            m_hist.delete();
         end else if (beat && gap >= MIN_INT) begin
            m_interval = gap + 1;
            m_anchor   = edge_n;
            m_busy     = 1;
            m_upd_edge = edge_n + DIVW + 2;
         end
      end else if (beat) begin
         m_armed  = 1;
         m_anchor = edge_n;
      end
      if (mload) begin
         nb = clampi(int'(mval));
         ns = 0;
         nv = 1;
         m_hist.delete();
      end
      if (nb != m_bpm || ns != m_src || nv != m_valid) begin
         ev.cyc   = edge_n;
         ev.bpm   = nb;
         ev.src   = ns;
         ev.valid = nv;
         chg_q.push_back(ev);
      end
      m_bpm   = nb;
      m_src   = ns;
      m_valid = nv;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk);
         edge_n++;
         if (rst) m_reset();
         else m_step();
      end
   end

   // ---------------- monitor ----------------
   ev_t        mev;
   logic [7:0] lb;
   logic       ls;
   logic       lv;
   int         mt;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            lb = 8'(DEF);
            ls = 1'b0;
            lv = 1'b0;
         end else begin
            while (chg_q.size() > 0 && chg_q[0].cyc < edge_n) begin
               mev = chg_q.pop_front();
               flag("missed_change", mev.cyc);
            end
            if (bpm !== lb || src !== ls || valid !== lv) begin
               if (chg_q.size() == 0)
                  flag("unexpected_change", -1);
               else begin
                  mev = chg_q.pop_front();
                  chk("change_edge", edge_n, mev.cyc);
                  chk("bpm_out", bpm, mev.bpm);
                  chk("source_out", src, mev.src);
                  chk("bpm_valid_out", valid, mev.valid);
               end
               lb = bpm;
               ls = src;
               lv = valid;
            end
            while (tick_q.size() > 0 && tick_q[0] < edge_n) begin
               mt = tick_q.pop_front();
               flag("missed_tick", mt);
            end
            if (tick === 1'b1) begin
               if (tick_q.size() == 0)
                  flag("unexpected_tick", -1);
               else begin
                  mt = tick_q.pop_front();
                  chk("tick_edge", edge_n, mt);
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic wait_n(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic fire();
      beat = 1'b1;
      @(negedge clk);
      beat = 1'b0;
   endtask

   task automatic man(int v);
      mval  = 8'(v);
      mload = 1'b1;
      @(negedge clk);
      mload = 1'b0;
   endtask

   initial begin
      int gap;
      int mid;

      wait_n(3);
      chk("rst_bpm", bpm, DEF);
      chk("rst_src", src, 0);
      chk("rst_valid", valid, 0);
      chk("rst_tick", tick, 0);
      #2 rst = 1'b0;

      // idle: ticks every 600 cycles
      wait_n(1300);

      // tracking with auto off leaves tempo alone
      auto_en = 1'b0;
      fire(); wait_n(299);
      fire(); wait_n(299);
      fire(); wait_n(40);
      chk("auto_off_bpm", bpm, 60);
      chk("auto_off_src", src, 0);
      wait_n(1300);

      // tracked lock at 120, then one 400-cycle interval
      auto_en = 1'b1;
      fire(); wait_n(299);
      fire(); wait_n(18);
      chk("lock_bpm", bpm, 120);
      chk("lock_src", src, 1);
      chk("lock_valid", valid, 1);
      wait_n(281);
      fire(); wait_n(399);
      fire(); wait_n(18);
      chk("avg_bpm", bpm, 112);

      // manual clamp to 240, 150-cycle tick period
      man(250);
      chk("man_bpm", bpm, 240);
      chk("man_src", src, 0);
      wait_n(400);

      // manual in the UPDATE cycle wins
      fire(); wait_n(17);
      man(20);
      chk("man_upd_bpm", bpm, 30);
      chk("man_upd_src", src, 0);

      // fresh lock, bounce, then timeout
      wait_n(281);
      fire(); wait_n(99);
      fire(); wait_n(1300);
      chk("timeout_bpm", bpm, 120);
      chk("timeout_src", src, 1);

      // reset while dividing
      auto_en = 1'b0;
      fire(); wait_n(299);
      fire(); wait_n(5);
      #2 rst = 1'b1;
      #1;
      chk("div_rst_bpm", bpm, DEF);
      chk("div_rst_src", src, 0);
      chk("div_rst_valid", valid, 0);
      chk("div_rst_tick", tick, 0);
      wait_n(3);
      #2 rst = 1'b0;
      wait_n(100);

      // randomized beats, auto enable and manual loads
      for (int i = 0; i < 25; i++) begin
         gap     = $urandom_range(60, 1400);
         auto_en = 1'($urandom_range(0, 1));
         fire();
         if ($urandom_range(0, 3) == 0) begin
            mid = $urandom_range(0, gap - 3);
            wait_n(mid);
            man($urandom_range(0, 255));
            wait_n(gap - 3 - mid);
         end else begin
            wait_n(gap - 1);
         end
      end
      wait_n(60);

      chk("chg_queue_drained", chg_q.size(), 0);
      chk("tick_queue_drained", tick_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
